// File: rtl/if_stage_if.sv
// Control/data bundle between the fetch stage and its neighbours.
// The neighbours are program load, decode, hazard and debug.
interface if_stage_if #(
    parameter int NB_DATA  = 32,
    parameter int NB_IADDR = 8
);
    logic                i_load_en;
    logic [NB_IADDR-1:0] i_load_addr;
    logic [NB_DATA-1:0]  i_load_data;
    logic                i_start;
    logic                i_jump;
    logic [NB_DATA-1:0]  i_addr2jump;
    logic                i_stall;
    logic                i_halt;
    logic                i_step_mode;
    logic                i_step;
    logic [NB_DATA-1:0]  o_instruction;
    logic [NB_DATA-1:0]  o_pcounter4;
    logic [NB_DATA-1:0]  o_pc;
    logic [1:0]          o_state;
    logic                o_halted;

    modport master (
        output i_load_en, i_load_addr, i_load_data, i_start, i_jump, i_addr2jump,
               i_stall, i_halt, i_step_mode, i_step,
        input  o_instruction, o_pcounter4, o_pc, o_state, o_halted
    );

    modport slave (
        input  i_load_en, i_load_addr, i_load_data, i_start, i_jump, i_addr2jump,
               i_stall, i_halt, i_step_mode, i_step,
        output o_instruction, o_pcounter4, o_pc, o_state, o_halted
    );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction fetch: PC, instruction memory with a load port, IF/ID register.
// An all-ones instruction word is the HALT marker that parks the stage.
module if_stage #(
    parameter int NB_DATA    = 32,
    parameter int IMEM_DEPTH = 256,
    parameter int NB_IADDR   = 8
) (
    input  logic         clk,
    input  logic         i_rst,
    if_stage_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } state_t;

    localparam logic [NB_DATA-1:0] HALT_WORD = '1;
    localparam logic [NB_DATA-1:0] NOP       = '0;

    state_t             state;
    logic               halted;
    logic [NB_DATA-1:0] pc;
    logic [NB_DATA-1:0] pc_plus4;
    logic [NB_DATA-1:0] instr_q;
    logic [NB_DATA-1:0] pc4_q;
    logic [NB_DATA-1:0] fetch_word;

    logic [NB_DATA-1:0] mem [IMEM_DEPTH];

    assign fetch_word = mem[pc[NB_IADDR+1:2]];
    assign pc_plus4   = pc + NB_DATA'(4);

    // Memory survives reset; writes land only while IDLE and not in reset.
    always_ff @(posedge clk) begin
        if (!i_rst && state == IDLE && bus.i_load_en)
            mem[bus.i_load_addr] <= bus.i_load_data;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state   <= IDLE;
            halted  <= 1'b0;
            pc      <= '0;
            instr_q <= NOP;
            pc4_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pc      <= '0;
                    instr_q <= NOP;
                    pc4_q   <= '0;
                    if (bus.i_start)
                        state <= RUN;
                end
                RUN: begin
                    // halt and stall freeze everything, including a pending jump
                    if (bus.i_halt || bus.i_stall) begin
                        pc      <= pc;
                    end else if (bus.i_jump) begin
                        pc      <= bus.i_addr2jump;
                        instr_q <= NOP;
                        pc4_q   <= '0;
                    end else if (bus.i_step_mode && !bus.i_step) begin
                        instr_q <= NOP;
                        pc4_q   <= '0;
                    end else begin
                        instr_q <= fetch_word;
                        pc4_q   <= pc_plus4;
                        if (fetch_word == HALT_WORD) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            pc <= pc_plus4;
                        end
                    end
                end
                HALTED: begin
                    halted <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_instruction = instr_q;
    assign bus.o_pcounter4   = pc4_q;
    assign bus.o_pc          = pc;
    assign bus.o_state       = state;
    assign bus.o_halted      = halted;
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: load/run/halt, stall, jump, step, load-in-RUN,
// debug halt and mid-run reset, with hand-computed expectations.
module tb_if_stage;
    localparam int NB_DATA  = 32;
    localparam int NB_IADDR = 8;

    logic clk = 1'b0;
    logic i_rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    if_stage_if #(.NB_DATA(NB_DATA), .NB_IADDR(NB_IADDR)) bus ();

    if_stage #(.NB_DATA(NB_DATA), .IMEM_DEPTH(256), .NB_IADDR(NB_IADDR)) dut (
        .clk  (clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] pc4, input logic [1:0] st);
        chk({tag, ".pc"},    bus.o_pc, pc);
        chk({tag, ".instr"}, bus.o_instruction, ins);
        chk({tag, ".pc4"},   bus.o_pcounter4, pc4);
        chk({tag, ".state"}, {30'd0, bus.o_state}, {30'd0, st});
        chk({tag, ".halted"}, {31'd0, bus.o_halted}, {31'd0, st == 2'b10});
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        bus.i_load_en   = 1'b1;
        bus.i_load_addr = a;
        bus.i_load_data = d;
        tick();
        bus.i_load_en   = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1;
        bus.i_load_en = 0; bus.i_load_addr = '0; bus.i_load_data = '0;
        bus.i_start = 0; bus.i_jump = 0; bus.i_addr2jump = '0;
        bus.i_stall = 0; bus.i_halt = 0; bus.i_step_mode = 0; bus.i_step = 0;
        tick(); tick();
        i_rst = 1'b0;
        chk_all("reset", 32'h0, 32'h0, 32'h0, 2'b00);

        // ---- phase 1: short program ending in HALT
        load(8'd0, 32'h20010005);
        load(8'd1, 32'h20020003);
        load(8'd2, 32'h00221820);
        load(8'd3, 32'hFFFFFFFF);
        chk_all("idle_after_load", 32'h0, 32'h0, 32'h0, 2'b00);
        bus.i_start = 1; tick(); bus.i_start = 0;
        chk_all("start", 32'h0, 32'h0, 32'h0, 2'b01);
        tick(); chk_all("f0", 32'h4, 32'h20010005, 32'h4, 2'b01);
        tick(); chk_all("f1", 32'h8, 32'h20020003, 32'h8, 2'b01);
        tick(); chk_all("f2", 32'hC, 32'h00221820, 32'hC, 2'b01);
        tick(); chk_all("halt_fetch", 32'hC, 32'hFFFFFFFF, 32'h10, 2'b10);
        bus.i_start = 1; bus.i_jump = 1; bus.i_addr2jump = 32'h40; bus.i_load_en = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_all("halted_hold", 32'hC, 32'hFFFFFFFF, 32'h10, 2'b10);
        end
        bus.i_start = 0; bus.i_jump = 0; bus.i_load_en = 0;

        // ---- phase 2: reset, extend program; last load coincides with start
        i_rst = 1; tick(); i_rst = 0;
        chk_all("reset2", 32'h0, 32'h0, 32'h0, 2'b00);
        for (int i = 3; i < 31; i++) load(8'(i), 32'h10000000 + i);
        bus.i_start = 1; load(8'd31, 32'h1000001F); bus.i_start = 0;
        chk_all("load_and_start", 32'h0, 32'h0, 32'h0, 2'b01);
        tick(); chk_all("r0", 32'h4, 32'h20010005, 32'h4, 2'b01);
        tick(); chk_all("r1", 32'h8, 32'h20020003, 32'h8, 2'b01);

        // stall at 0x08 with a jump that must be ignored
        bus.i_stall = 1; bus.i_jump = 1; bus.i_addr2jump = 32'h80;
        tick(); chk_all("stall1", 32'h8, 32'h20020003, 32'h8, 2'b01);
        tick(); chk_all("stall2", 32'h8, 32'h20020003, 32'h8, 2'b01);
        bus.i_stall = 0; bus.i_jump = 0;
        tick(); chk_all("resume", 32'hC, 32'h00221820, 32'hC, 2'b01);
        tick(); chk_all("r3", 32'h10, 32'h10000003, 32'h10, 2'b01);

        // jump from 0x10 to 0x40
        bus.i_jump = 1; bus.i_addr2jump = 32'h40;
        tick(); bus.i_jump = 0;
        chk_all("jump_flush", 32'h40, 32'h0, 32'h0, 2'b01);
        tick(); chk_all("jump_target", 32'h44, 32'h10000010, 32'h44, 2'b01);

        // single-step: one fetch per pulse, two bubbles between
        bus.i_step_mode = 1;
        for (int p = 0; p < 2; p++) begin
            bus.i_step = 1; tick(); bus.i_step = 0;
            chk_all("step_fetch", 32'h48 + 4 * p, 32'h10000011 + p, 32'h48 + 4 * p, 2'b01);
            tick(); chk_all("step_bub1", 32'h48 + 4 * p, 32'h0, 32'h0, 2'b01);
            tick(); chk_all("step_bub2", 32'h48 + 4 * p, 32'h0, 32'h0, 2'b01);
        end
        bus.i_step_mode = 0;

        // load in RUN must not change memory
        bus.i_load_en = 1; bus.i_load_addr = 8'd2; bus.i_load_data = 32'hDEADBEEF;
        tick(); bus.i_load_en = 0;
        chk_all("run_load", 32'h50, 32'h10000013, 32'h50, 2'b01);
        bus.i_jump = 1; bus.i_addr2jump = 32'h8;
        tick(); bus.i_jump = 0;
        chk_all("jump_back", 32'h8, 32'h0, 32'h0, 2'b01);
        tick(); chk_all("refetch_m2", 32'hC, 32'h00221820, 32'hC, 2'b01);

        // debug halt for 4 cycles, jump ignored
        bus.i_halt = 1; bus.i_jump = 1; bus.i_addr2jump = 32'h100;
        for (int i = 0; i < 4; i++) begin
            tick(); chk_all("dbg_halt", 32'hC, 32'h00221820, 32'hC, 2'b01);
        end
        bus.i_halt = 0; bus.i_jump = 0;
        tick(); chk_all("after_halt", 32'h10, 32'h10000003, 32'h10, 2'b01);
        for (int i = 0; i < 4; i++) tick();
        chk_all("at_0x20", 32'h20, 32'h10000007, 32'h20, 2'b01);

        // reset mid-RUN overrides start and a load attempt
        i_rst = 1; bus.i_start = 1;
        bus.i_load_en = 1; bus.i_load_addr = 8'd0; bus.i_load_data = 32'h0;
        tick();
        i_rst = 0; bus.i_start = 0; bus.i_load_en = 0;
        chk_all("mid_reset", 32'h0, 32'h0, 32'h0, 2'b00);
        bus.i_start = 1; tick(); bus.i_start = 0;
        tick(); chk_all("replay0", 32'h4, 32'h20010005, 32'h4, 2'b01);
        tick(); chk_all("replay1", 32'h8, 32'h20020003, 32'h8, 2'b01);
        tick(); chk_all("replay2", 32'hC, 32'h00221820, 32'hC, 2'b01);
        tick(); chk_all("replay3", 32'h10, 32'h10000003, 32'h10, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Holds the PC, the instruction memory and its program-load write port, and the IF/ID pipeline register.
- Produces the instruction and PC+4 word consumed by decode.
- Consumes decode's jump request and target, plus the hazard unit's stall and the debug unit's halt/step controls.

Parameters:
- NB_DATA, 32, instruction/PC width.
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words (power of two).
- NB_IADDR, 8, word-index width = log2(IMEM_DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_load_en  in  1  program-load write strobe (accepted only in IDLE).
- i_load_addr  in  NB_IADDR  word index to write.
- i_load_data  in  NB_DATA  instruction word to write.
- i_start  in  1  begin execution from PC 0 (accepted only in IDLE).
- i_jump  in  1  decode requests redirect this cycle.
- i_addr2jump  in  NB_DATA  byte address of redirect target.
- i_stall  in  1  load-use stall from hazard unit.
- i_halt  in  1  debug freeze of the whole stage.
- i_step_mode  in  1  single-step enable.
- i_step  in  1  one-cycle pulse advancing one fetch in step mode.
- o_instruction  out  NB_DATA  IF/ID instruction.
- o_pcounter4  out  NB_DATA  IF/ID: byte address of o_instruction + 4.
- o_pc  out  NB_DATA  current fetch PC (byte address).
- o_state  out  2  00 IDLE, 01 RUN, 10 HALTED.
- o_halted  out  1  high while in HALTED.

Behaviour:
- Reset (i_rst=1 at edge):
  - state=IDLE, PC=0, o_instruction=0 (NOP), o_pcounter4=0.
  - Instruction memory contents are NOT cleared.
  - Reset overrides every other input, including mid-RUN and mid-load.
- Memory:
  - Word index = PC[NB_IADDR+1:2]; PC[1:0] ignored.
  - Addresses beyond depth wrap modulo IMEM_DEPTH.
  - Read is combinational at PC; the fetched word is registered into IF/ID, so latency is 1 cycle from PC to o_instruction.
- IDLE:
  - i_load_en=1 writes mem[i_load_addr] <= i_load_data.
  - IF/ID holds NOP; PC=0.
  - i_start=1 -> RUN next cycle. If i_load_en and i_start are both high, the write completes and the transition still occurs.
- RUN, per cycle, first matching rule applies:
  - i_load_en in RUN: ignored, memory unchanged.
  - i_halt: PC and IF/ID hold all values. i_jump is ignored (decode is frozen too).
  - i_stall: PC and IF/ID hold. A simultaneous i_jump is ignored, because decode re-presents it after the stall.
  - i_jump: PC <= i_addr2jump; IF/ID <= NOP with o_pcounter4=0 (flush the wrong-path fetch). There is no delay slot. Jump is honoured in step mode even without i_step.
  - i_step_mode=1 and i_step=0: PC holds; IF/ID <= NOP (bubble).
  - Otherwise, normal fetch:
    - IF/ID <= {mem[PC], PC+4}.
    - If the fetched word is 32'hFFFFFFFF: PC holds at the HALT address and state -> HALTED.
    - Else PC <= PC+4. Wrap past the top of memory is modulo 2^NB_DATA on PC; indexing wraps per the memory rule.
- HALTED:
  - PC frozen.
  - IF/ID continues to hold the HALT word, so decode keeps o_stop asserted.
  - All inputs except i_rst are ignored; only reset leaves HALTED.
- o_state and o_halted are registered and change on the same edge as the state transition.

Test Plan:
- Reset, load mem[0..3] = {0x20010005, 0x20020003, 0x00221820, 0xFFFFFFFF}, then i_start -> o_instruction shows those words on consecutive cycles, o_pcounter4 = 4, 8, 12, 16. The cycle after the HALT fetch: o_halted=1, o_pc=0x0C, o_instruction holds 0xFFFFFFFF indefinitely.
- RUN, i_stall=1 for 2 cycles while o_pc=0x08 -> o_pc and o_instruction unchanged for both cycles. Fetch resumes at 0x08, and a simultaneous i_jump during the stall has no effect.
- i_jump=1, i_addr2jump=0x40 while o_pc=0x10 -> next cycle o_pc=0x40, o_instruction=0, o_pcounter4=0. The cycle after that, o_instruction=mem[16], o_pcounter4=0x44.
- i_step_mode=1, i_step pulsed every 3rd cycle -> exactly one non-NOP instruction per pulse, two NOP bubbles between, PC advances by 4 per pulse only.
- i_load_en=1 in RUN to address 2 with 0xDEADBEEF -> mem[2] unchanged on re-fetch. i_halt=1 for 4 cycles -> all outputs frozen.
- Assert i_rst mid-RUN at o_pc=0x20 -> next cycle state=IDLE, o_pc=0, o_instruction=0. i_start without reload replays the original program (memory preserved).
